// File: rtl/mips_fetch_pkg.sv
// Shared types and helpers for the MIPS instruction-fetch stage.
// FSM state encoding, instruction size and the J-type target calculation.
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        VALID,
        ERR
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    // J-type target: upper nibble of pc+4, 26-bit word index, word aligned.
    function automatic logic [31:0] jump_target(input logic [31:0] pcplus4,
                                                input logic [25:0] instr);
        return {pcplus4[31:28], instr, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection for the fetch stage: jump beats branch beats pc+4.
// Purely combinational; the result is always word aligned.
import mips_fetch_pkg::*;

module pc_next (
    input  logic [31:0] pcplus4,
    input  logic [25:0] instr_index,
    input  logic [31:0] signimm,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] nextpc
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    logic [31:0] target;

    always_comb begin
        target = pcplus4;
        if (jump) begin
            target = jump_target(pcplus4, instr_index);
        end else if (pcsrc) begin
            target = pcplus4 + (signimm << 2);
        end
        nextpc = target & ALIGN_MASK;
    end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC register, one-deep instruction register and
// memory handshake FSM. Optional retire counter enabled by FETCH_RETIRE_CNT_EN.
import mips_fetch_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0040_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        fetch_err
`ifdef FETCH_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_count
`endif
);

    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;
    // Keep at least one bit so a disabled timeout still elaborates cleanly.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [31:0]      nextpc;

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retire_q, retire_d;
`endif

    pc_next u_pc_next (
        .pcplus4     (pcplus4),
        .instr_index (instr_q[25:0]),
        .signimm     (signimm),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .nextpc      (nextpc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
`ifdef FETCH_RETIRE_CNT_EN
        retire_d = retire_q;
`endif
        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    wait_d  = '0;
                    state_d = VALID;
                end else begin
                    if (wait_q != CNT_MAX) begin
                        wait_d = wait_q + CNT_W'(1);
                    end
                    if ((TIMEOUT_CYCLES != 0) && (wait_d == TIMEOUT_VAL)) begin
                        state_d = ERR;
                    end
                end
            end
            VALID: begin
                if (instr_ack) begin
                    pc_d    = nextpc;
                    state_d = FETCH;
`ifdef FETCH_RETIRE_CNT_EN
                    retire_d = retire_q + 32'd1;
`endif
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

`ifdef FETCH_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`endif

    // Gate with reset so the request drops the instant reset is asserted.
    assign imem_req    = (state_q == FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == VALID);
    assign fetch_err   = (state_q == ERR);
    assign pc          = pc_q;
    assign pcplus4     = pc_q + 32'(INSTR_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: sequential fetch, branch, jump,
// wait states, stall, wrap-around, timeout and asynchronous reset.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ack;
    logic        pcsrc;
    logic        jump;
    logic [31:0] signimm;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        fetch_err;
`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    int total = 0;
    int bad   = 0;
    int exp_retire = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC       (RST_PC),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ack    (instr_ack),
        .pcsrc        (pcsrc),
        .jump         (jump),
        .signimm      (signimm),
        .pc           (pc),
        .pcplus4      (pcplus4),
        .fetch_err    (fetch_err)
`ifdef FETCH_RETIRE_CNT_EN
        ,
        .retire_count (retire_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle memory response; instr must be valid the next cycle.
    task automatic do_fetch(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        check("fetch_valid", {31'd0, instr_valid}, 32'd1);
        check("fetch_instr", instr, word);
        check("fetch_req_low", {31'd0, imem_req}, 32'd0);
    endtask

    // Ack with controller inputs; the new request must appear the next cycle.
    task automatic do_ack(input logic br, input logic jp, input logic [31:0] imm,
                          input logic [31:0] exp_addr);
        instr_ack = 1'b1;
        pcsrc     = br;
        jump      = jp;
        signimm   = imm;
        step();
        instr_ack = 1'b0;
        pcsrc     = 1'b0;
        jump      = 1'b0;
        signimm   = 32'h0;
        exp_retire++;
        check("ack_req", {31'd0, imem_req}, 32'd1);
        check("ack_addr", imem_addr, exp_addr);
        check("ack_valid_low", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_RETIRE_CNT_EN
        check("retire_count", retire_count, 32'(exp_retire));
`endif
    endtask

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        instr_ack  = 1'b0;
        pcsrc      = 1'b0;
        jump       = 1'b0;
        signimm    = 32'h0;

        // Reset state
        #2;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", pc, RST_PC);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        #10;
        reset = 1'b0;
        #1;
        check("first_req", {31'd0, imem_req}, 32'd1);
        check("first_addr", imem_addr, 32'h0040_0000);
        check("first_pcplus4", pcplus4, 32'h0040_0004);

        // Sequential fetch
        do_fetch(32'h2002_0005);
        do_ack(1'b0, 1'b0, 32'h0, 32'h0040_0004);
        do_fetch(32'h2003_0006);
        do_ack(1'b0, 1'b0, 32'h0, 32'h0040_0008);
        do_fetch(32'h0000_0020);
        do_ack(1'b0, 1'b0, 32'h0, 32'h0040_000C);
        do_fetch(32'h0000_0020);
        do_ack(1'b0, 1'b0, 32'h0, 32'h0040_0010);

        // Backward branch from 0x0040_0010: 0x0040_0014 - 16
        do_fetch(32'h1000_FFFC);
        do_ack(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0040_0004);
        // Jump back to 0x0040_0010, then not-taken branch ignores signimm
        do_fetch(32'h0810_0004);
        do_ack(1'b0, 1'b1, 32'h0, 32'h0040_0010);
        do_fetch(32'h1000_FFFC);
        do_ack(1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0040_0014);

        // Walk to 0x0040_0020, then jump wins over pcsrc
        do_fetch(32'h0);
        do_ack(1'b0, 1'b0, 32'h0, 32'h0040_0018);
        do_fetch(32'h0);
        do_ack(1'b0, 1'b0, 32'h0, 32'h0040_001C);
        do_fetch(32'h0);
        do_ack(1'b0, 1'b0, 32'h0, 32'h0040_0020);
        check("pcplus4_20", pcplus4, 32'h0040_0024);
        do_fetch(32'h0810_0004);
        do_ack(1'b1, 1'b1, 32'h0000_0100, 32'h0040_0010);

        // Wait states; a stray ack in FETCH must be ignored
        instr_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, 32'h0040_0010);
            check("wait_valid", {31'd0, instr_valid}, 32'd0);
        end
        instr_ack = 1'b0;
        do_fetch(32'h8C08_0000);

        // Stall: no ack for 5 cycles, memory activity ignored
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_instr", instr, 32'h8C08_0000);
            check("stall_pc", pc, 32'h0040_0010);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        imem_ready = 1'b0;
        do_ack(1'b0, 1'b0, 32'h0, 32'h0040_0014);

        // Branch to 0xFFFF_FFFC, then sequential wrap to 0
        do_fetch(32'h1000_0000);
        do_ack(1'b1, 1'b0, 32'h3FEF_FFF9, 32'hFFFF_FFFC);
        check("wrap_pcplus4", pcplus4, 32'h0000_0000);
        do_fetch(32'h0);
        do_ack(1'b0, 1'b0, 32'h0, 32'h0000_0000);

        // Timeout after the 8th unready cycle
        for (int i = 0; i < 7; i++) begin
            step();
            check("pre_timeout_err", {31'd0, fetch_err}, 32'd0);
            check("pre_timeout_req", {31'd0, imem_req}, 32'd1);
        end
        step();
        check("timeout_err", {31'd0, fetch_err}, 32'd1);
        check("timeout_req", {31'd0, imem_req}, 32'd0);
        imem_ready = 1'b1;
        instr_ack  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("err_sticky", {31'd0, fetch_err}, 32'd1);
            check("err_valid", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_RETIRE_CNT_EN
            check("err_retire_frozen", retire_count, 32'(exp_retire));
`endif
        end
        imem_ready = 1'b0;
        instr_ack  = 1'b0;

        // Asynchronous reset mid-cycle
        #2;
        reset = 1'b1;
        #1;
        check("arst_err", {31'd0, fetch_err}, 32'd0);
        check("arst_req", {31'd0, imem_req}, 32'd0);
        check("arst_addr", imem_addr, RST_PC);
`ifdef FETCH_RETIRE_CNT_EN
        check("arst_retire", retire_count, 32'd0);
`endif
        #3;
        reset = 1'b0;
        #1;
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, RST_PC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
